// File: rtl/board_engine.sv
// 4x4 lights-out core: edge-detects button levels, moves the cursor, toggles
// the cross-shaped mask on presses and reports the solved board to the status FSM.
module board_engine (
    input  logic        clk_d,
    input  logic        rst,
    input  logic [1:0]  game_status,
    input  logic [1:0]  board_sel,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_press,
    output logic [15:0] board,
    output logic [3:0]  cursor,
    output logic        active,
    output logic        win_flag
);

    localparam logic [1:0] ST_CHOSE_BOARD  = 2'b00;
    localparam logic [1:0] ST_GAMING       = 2'b01;
    localparam logic [1:0] ST_GAME_INITIAL = 2'b10;
    localparam logic [1:0] ST_WINNED       = 2'b11;

    typedef enum logic [1:0] {LOAD, PLAY, SOLVED} state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic [15:0] r_board;
    logic [15:0] w_nextBoard;
    logic [3:0]  r_cursor;
    logic [3:0]  w_nextCursor;
    logic        r_active;
    logic        w_nextActive;
    logic        r_win;
    logic        w_nextWin;
    logic [4:0]  r_prevBtn;
    logic [4:0]  w_btn;
    logic [4:0]  w_evt;
    logic [15:0] w_preset;
    logic [15:0] w_mask;

    // Button order {press, up, down, left, right}; MSB has the highest priority.
    assign w_btn = {btn_press, btn_up, btn_down, btn_left, btn_right};
    assign w_evt = w_btn & ~r_prevBtn;

    always_comb begin
        w_preset = 16'h0272;
        case (board_sel)
            2'd0: w_preset = 16'h0272;
            2'd1: w_preset = 16'h0013;
            2'd2: w_preset = 16'hC813;
            2'd3: w_preset = 16'h4E40;
            default: w_preset = 16'h0272;
        endcase
    end

    // Cursor {row,col} is also the bit index of the cell, so neighbours are +-1 / +-4.
    always_comb begin
        w_mask = 16'h0000;
        w_mask[r_cursor] = 1'b1;
        if (r_cursor[3:2] != 2'd0) w_mask[r_cursor - 4'd4] = 1'b1;
        if (r_cursor[3:2] != 2'd3) w_mask[r_cursor + 4'd4] = 1'b1;
        if (r_cursor[1:0] != 2'd0) w_mask[r_cursor - 4'd1] = 1'b1;
        if (r_cursor[1:0] != 2'd3) w_mask[r_cursor + 4'd1] = 1'b1;
    end

    always_comb begin
        w_nextState  = r_state;
        w_nextBoard  = r_board;
        w_nextCursor = r_cursor;
        w_nextActive = 1'b0;
        w_nextWin    = r_win;
        if (game_status == ST_CHOSE_BOARD) begin
            w_nextState  = LOAD;
            w_nextBoard  = w_preset;
            w_nextCursor = 4'd0;
            w_nextWin    = 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    w_nextBoard  = w_preset;
                    w_nextCursor = 4'd0;
                    w_nextWin    = 1'b0;
                    if (game_status == ST_GAMING || game_status == ST_GAME_INITIAL)
                        w_nextState = PLAY;
                end
                PLAY: begin
                    if (r_board == 16'h0000) begin
                        w_nextState = SOLVED;
                        w_nextWin   = 1'b1;
                    end else if (game_status == ST_WINNED) begin
                        w_nextState = SOLVED;
                    end else if (w_evt[4]) begin
                        w_nextBoard  = r_board ^ w_mask;
                        w_nextActive = 1'b1;
                    end else if (w_evt[3]) begin
                        if (r_cursor[3:2] != 2'd0) w_nextCursor[3:2] = r_cursor[3:2] - 2'd1;
                    end else if (w_evt[2]) begin
                        if (r_cursor[3:2] != 2'd3) w_nextCursor[3:2] = r_cursor[3:2] + 2'd1;
                    end else if (w_evt[1]) begin
                        if (r_cursor[1:0] != 2'd0) w_nextCursor[1:0] = r_cursor[1:0] - 2'd1;
                    end else if (w_evt[0]) begin
                        if (r_cursor[1:0] != 2'd3) w_nextCursor[1:0] = r_cursor[1:0] + 2'd1;
                    end
                end
                SOLVED: begin
                end
                default: w_nextState = LOAD;
            endcase
        end
    end

    // Previous levels reset to 1 so a button held through reset yields no event.
    always_ff @(posedge clk_d) begin
        if (rst) begin
            r_state   <= LOAD;
            r_board   <= 16'h0000;
            r_cursor  <= 4'd0;
            r_active  <= 1'b0;
            r_win     <= 1'b0;
            r_prevBtn <= 5'b11111;
        end else begin
            r_state   <= w_nextState;
            r_board   <= w_nextBoard;
            r_cursor  <= w_nextCursor;
            r_active  <= w_nextActive;
            r_win     <= w_nextWin;
            r_prevBtn <= w_btn;
        end
    end

    assign board    = r_board;
    assign cursor   = r_cursor;
    assign active   = r_active;
    assign win_flag = r_win;

endmodule
